// File: rtl/mem_access_pkg.sv
// mem_access_pkg: FSM state encoding, access size codes and default address limit
// for mem_access_unit and lane_align.
package mem_access_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WSTORE, RESP} state_e;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [31:0] DEF_ADDR_LIMIT = 32'h0000_3000;
endpackage

// File: rtl/lane_align.sv
// lane_align: little-endian lane steering for sub-word stores (merge) and loads (extract/extend).
// Ports: size/sign_ext/offset describe the access; word is the memory word read;
// wdata is right-aligned store data; merged is word with the new lanes
// inserted; loaded is the right-aligned, zero- or sign-extended load result.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] loaded
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] lanes;
  always_comb begin
    sh     = (size == SZ_H) ? {offset[1], 4'b0000} : {offset, 3'b000};
    mask   = (size == SZ_B) ? 32'h0000_00ff << sh : (size == SZ_H) ? 32'h0000_ffff << sh : '1;
    merged = (word & ~mask) | ((wdata << sh) & mask);
    lanes  = word >> sh;
    loaded = (size == SZ_B) ? {{24{sign_ext & lanes[7]}}, lanes[7:0]} :
             (size == SZ_H) ? {{16{sign_ext & lanes[15]}}, lanes[15:0]} : word;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store unit over a word-wide data memory with sub-word
// read-modify-write stores, alignment/range checking and a valid/ready response.
// Ports: req_* is the CPU request (ready only in IDLE); resp_* is the held
// completion; mem_* drives a combinational-read, word-write data memory, with
// mem_pc carrying the issuing PC for write logging. reset is async active-low.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_pc
);
  state_e      state, state_nx;
  logic        write_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q, data_q, merged, loaded;
  logic        accept, bad;

  assign accept = req_valid & req_ready;
  assign bad = (req_size == 2'd3) || (req_size == SZ_H && req_addr[0]) ||
               (req_size == SZ_W && req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);

  lane_align u_align (
    .size    (size_q),
    .sign_ext(signed_q),
    .offset  (addr_q[1:0]),
    .word    (mem_rdata),
    .wdata   (wdata_q),
    .merged  (merged),
    .loaded  (loaded)
  );

  // data_q holds the extracted load result, or the merged word of a sub-word
  // store until WSTORE, after which it is cleared so stores respond with 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= bad;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        pc_q     <= req_pc;
        data_q   <= '0;
      end
      if (state == LOAD) data_q <= loaded;
      if (state == RMW_READ) data_q <= merged;
      if (state == WSTORE) data_q <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = bad ? RESP : !req_write ? LOAD : (req_size == SZ_W) ? WSTORE : RMW_READ;
      LOAD:     state_nx = RESP;
      RMW_READ: state_nx = WSTORE;
      WSTORE:   state_nx = RESP;
      RESP:     if (resp_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign req_ready  = reset && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_error = resp_valid & err_q;
  assign resp_rdata = resp_valid ? data_q : '0;
  assign mem_we     = (state == WSTORE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = mem_we ? ((size_q == SZ_W) ? wdata_q : data_q) : '0;
  assign mem_pc     = pc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_ready, resp_error, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata, mem_pc;
  logic [31:0] env_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  int          errors = 0;
  int          checks = 0;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_pc    (mem_pc)
  );

  always #5 clk = ~clk;
  assign mem_rdata = env_mem[mem_addr[13:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_pc", mem_pc, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input int stall);
    int n, lat, cyc, we_cnt, we_cyc, off;
    logic err;
    logic [31:0] word, exp_rd, we_a, we_d, pc;
    pc = $urandom;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    err = (n == 0) ? 1'b1 : ((a % n) != 0 || a >= 32'h3000);
    off = int'(a[1:0]);
    word = ref_mem[a[13:2]];
    exp_rd = 32'd0;
    if (!err && !w) begin
      for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = word[8*(off+k) +: 8];
      if (sg && n < 4 && exp_rd[8*n-1])
        for (int k = n; k < 4; k++) exp_rd[8*k +: 8] = 8'hff;
    end
    if (!err && w)
      for (int k = 0; k < n; k++) word[8*(off+k) +: 8] = d[8*k +: 8];
    lat = err ? 1 : (w && n < 4) ? 3 : 2;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d; req_pc = pc;
    req_valid = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; we_cnt = 0; we_cyc = 0; we_a = 0; we_d = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        we_cnt++; we_cyc = cyc; we_a = mem_addr; we_d = mem_wdata;
        env_mem[mem_addr[13:2]] = mem_wdata;
      end
      if (resp_valid) break;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_error", 32'(resp_error), 32'(err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("we_count", 32'(we_cnt), (!err && w) ? 32'd1 : 32'd0);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    check("mem_pc", mem_pc, pc);
    check("mem_addr_hold", mem_addr, {a[31:2], 2'b00});
    check("mem_wdata_idle", mem_wdata, 32'd0);
    if (!err && w) begin
      check("we_cycle", 32'(we_cyc), 32'(lat - 1));
      check("we_addr", we_a, {a[31:2], 2'b00});
      check("we_data", we_d, word);
      ref_mem[a[13:2]] = word;
    end
    check("mem_word", env_mem[a[13:2]], ref_mem[a[13:2]]);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_rdata", resp_rdata, exp_rd);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_we", 32'(mem_we), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r, a;
    for (int i = 0; i < 4096; i++) begin
      r = $urandom;
      env_mem[i] = r;
      ref_mem[i] = r;
    end
    env_mem[4] = 32'h8899_aabb;
    ref_mem[4] = 32'h8899_aabb;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 0; req_wdata = 0; req_pc = 0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    #1 check("ready_after_reset", 32'(req_ready), 32'd1);

    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    check("signed_byte_word", ref_mem[4], 32'h8899_aabb);
    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 0);
    check("half_store_word", env_mem[4], 32'h1234_aabb);
    access(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 0);
    access(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5);

    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h55;
    req_pc = 32'hdead_beef; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_no_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    #1 check_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      check("reset_no_we", 32'(mem_we), 32'd0);
    end
    reset = 1'b1;
    check("abandoned_word", env_mem[8], ref_mem[8]);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h2ff8 + $urandom_range(0, 15) : $urandom_range(0, 32'h2fff);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
